// File: rtl/mcu_serializer.sv
// rtl/mcu_serializer.sv - double-buffered MCU block drain emitting one coefficient per cycle
// Pops whole blocks from the MCU FIFO and streams them in zigzag or raster order.
module mcu_serializer #(
  parameter int MCU_SIZE  = 8,
  parameter int BIT_WIDTH = 12,
  parameter int ZIGZAG    = 1
) (
  input  logic                                                clk,
  input  logic                                                rst,
  output logic                                                o_re,
  input  logic                                                i_empty,
  input  logic [0:MCU_SIZE-1][0:MCU_SIZE-1][BIT_WIDTH-1:0]    i_mcu,
  input  logic                                                i_last,
  input  logic                                                i_valid,
  output logic [BIT_WIDTH-1:0]                                o_data,
  output logic                                                o_valid,
  input  logic                                                i_ready,
  output logic                                                o_first,
  output logic                                                o_last
);

  localparam int N  = MCU_SIZE * MCU_SIZE;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef logic [0:MCU_SIZE-1][0:MCU_SIZE-1][BIT_WIDTH-1:0] mcu_t;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} buf_state_t;

  // Entry k holds the bit-slot of element k inside the flattened block;
  // [0][0] sits in the most significant slot because of the ascending ranges.
  function automatic logic [N*KW-1:0] build_order();
    logic [N*KW-1:0] tbl;
    int idx, r, c, r0;
    tbl = '0;
    idx = 0;
    for (int s = 0; s < 2*MCU_SIZE-1; s++) begin
      if (s % 2 == 0) r0 = (s < MCU_SIZE) ? s : MCU_SIZE - 1;
      else            r0 = (s < MCU_SIZE) ? 0 : s - MCU_SIZE + 1;
      for (int i = 0; i < MCU_SIZE; i++) begin
        r = (s % 2 == 0) ? r0 - i : r0 + i;
        c = s - r;
        if (r >= 0 && r < MCU_SIZE && c >= 0 && c < MCU_SIZE) begin
          tbl[idx*KW +: KW] = KW'(N - 1 - ((ZIGZAG != 0) ? r*MCU_SIZE + c : idx));
          idx++;
        end
      end
    end
    return tbl;
  endfunction

  localparam logic [N*KW-1:0] ORDER = build_order();

  buf_state_t             state, state_nxt;
  mcu_t                   active_mcu, shadow_mcu;
  logic                   active_last, shadow_last;
  logic                   pend;
  logic [KW-1:0]          k;
  logic                   active_valid, shadow_valid;
  logic                   acc, hs, fin;
  logic                   load_active, load_shadow, promote;
  logic [N*BIT_WIDTH-1:0] active_flat;
  logic [KW-1:0]          pos;

  assign active_valid = (state != S_EMPTY);
  assign shadow_valid = (state == S_TWO);
  // Returns without a matching read (e.g. straddling reset) are dropped.
  assign acc          = i_valid & pend;
  assign hs           = o_valid & i_ready;
  assign fin          = hs & (k == K_LAST);

  assign o_re    = !rst & !i_empty & !pend & !shadow_valid & !(active_valid & pend);
  assign o_valid = active_valid;
  assign o_first = o_valid & (k == '0);
  assign o_last  = o_valid & (k == K_LAST) & active_last;

  assign active_flat = active_mcu;
  assign pos         = ORDER[k*KW +: KW];
  assign o_data      = active_flat[pos*BIT_WIDTH +: BIT_WIDTH];

  always_comb begin
    state_nxt   = state;
    load_active = 1'b0;
    load_shadow = 1'b0;
    promote     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (acc) begin
          state_nxt   = S_ONE;
          load_active = 1'b1;
        end
      end
      S_ONE: begin
        if (fin && acc) begin
          load_active = 1'b1;
        end else if (fin) begin
          state_nxt = S_EMPTY;
        end else if (acc) begin
          state_nxt   = S_TWO;
          load_shadow = 1'b1;
        end
      end
      S_TWO: begin
        if (fin) begin
          state_nxt = S_ONE;
          promote   = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_EMPTY;
      pend        <= 1'b0;
      k           <= '0;
      active_mcu  <= '0;
      active_last <= 1'b0;
      shadow_mcu  <= '0;
      shadow_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (o_re)         pend <= 1'b1;
      else if (i_valid) pend <= 1'b0;
      if (fin)          k <= '0;
      else if (hs)      k <= k + 1'b1;
      if (load_active) begin
        active_mcu  <= i_mcu;
        active_last <= i_last;
      end else if (promote) begin
        active_mcu  <= shadow_mcu;
        active_last <= shadow_last;
      end
      if (load_shadow) begin
        shadow_mcu  <= i_mcu;
        shadow_last <= i_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(i_valid && state == S_TWO));
  end

endmodule

// File: tb/tb_mcu_serializer.sv
// tb/tb_mcu_serializer.sv - scoreboard bench for mcu_serializer (zigzag and raster instances)
// A FIFO model feeds both instances; a monitor checks every cycle against a queue model.
module tb_mcu_serializer;

  localparam int M  = 8;
  localparam int N  = M * M;
  localparam int BW = 12;

  typedef logic [0:M-1][0:M-1][BW-1:0] mcu_t;
  typedef struct { mcu_t d; logic last; } blk_t;
  typedef struct { logic [BW-1:0] zz; logic [BW-1:0] rs; logic first; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_empty = 1'b1;
  mcu_t i_mcu = '0;
  logic i_last = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b0;

  logic          o_re_zz, o_valid_zz, o_first_zz, o_last_zz;
  logic          o_re_rs, o_valid_rs, o_first_rs, o_last_rs;
  logic [BW-1:0] o_data_zz, o_data_rs;

  blk_t fifo[$];
  exp_t sb[$];
  int   zz_lin[N];
  int   n_checks = 0;
  int   n_fail = 0;
  int   emitted = 0;
  int   ready_pct = 100;
  logic hold_empty = 1'b0;
  logic re_s = 1'b0;
  logic rst_s = 1'b1;

  always #5 clk = ~clk;

  mcu_serializer #(.MCU_SIZE(M), .BIT_WIDTH(BW), .ZIGZAG(1)) u_zz (
    .clk(clk), .rst(rst), .o_re(o_re_zz), .i_empty(i_empty), .i_mcu(i_mcu),
    .i_last(i_last), .i_valid(i_valid), .o_data(o_data_zz), .o_valid(o_valid_zz),
    .i_ready(i_ready), .o_first(o_first_zz), .o_last(o_last_zz)
  );

  mcu_serializer #(.MCU_SIZE(M), .BIT_WIDTH(BW), .ZIGZAG(0)) u_rs (
    .clk(clk), .rst(rst), .o_re(o_re_rs), .i_empty(i_empty), .i_mcu(i_mcu),
    .i_last(i_last), .i_valid(i_valid), .o_data(o_data_rs), .o_valid(o_valid_rs),
    .i_ready(i_ready), .o_first(o_first_rs), .o_last(o_last_rs)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic add_block(input bit rnd, input logic last);
    blk_t b;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++)
        b.d[r][c] = rnd ? BW'($urandom) : BW'(r*M + c);
    b.last = last;
    fifo.push_back(b);
  endtask

  task automatic push_expected(input blk_t b);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.zz    = b.d[zz_lin[k] / M][zz_lin[k] % M];
      e.rs    = b.d[k / M][k % M];
      e.first = (k == 0);
      e.last  = (k == N-1) && b.last;
      sb.push_back(e);
    end
  endtask

  // One clock of the FIFO model: a read strobed last cycle returns data now.
  task automatic step();
    blk_t b;
    @(posedge clk);
    rst_s = rst;
    #1;
    if (rst_s) sb.delete();
    i_valid = 1'b0;
    if (re_s && fifo.size() > 0) begin
      b = fifo.pop_front();
      i_mcu   = b.d;
      i_last  = b.last;
      i_valid = 1'b1;
      push_expected(b);
    end
    i_empty = hold_empty || (fifo.size() == 0);
    i_ready = rst ? 1'b0 : ($urandom_range(99) < ready_pct);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((fifo.size() > 0 || sb.size() > 0 || i_valid) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= max), 32'd0);
  endtask

  initial begin : monitor
    int   held;
    logic exp_re, exp_v;
    exp_t e;
    forever begin
      @(negedge clk);
      re_s   = o_re_zz;
      held   = (sb.size() + N - 1) / N - (i_valid ? 1 : 0);
      exp_re = !rst && !i_empty && !i_valid && (held < 2);
      chk("o_re_zz", 32'(o_re_zz), 32'(exp_re));
      chk("o_re_rs", 32'(o_re_rs), 32'(exp_re));
      if (rst_s) begin
        chk("rst_valid", 32'({o_valid_zz, o_valid_rs}), 32'd0);
        chk("rst_first", 32'({o_first_zz, o_first_rs}), 32'd0);
        chk("rst_last", 32'({o_last_zz, o_last_rs}), 32'd0);
        chk("rst_data", 32'({o_data_zz, o_data_rs}), 32'd0);
      end else begin
        exp_v = (held > 0);
        chk("o_valid_zz", 32'(o_valid_zz), 32'(exp_v));
        chk("o_valid_rs", 32'(o_valid_rs), 32'(exp_v));
        if (o_valid_zz && sb.size() > 0) begin
          e = sb[0];
          chk("o_data_zz", 32'(o_data_zz), 32'(e.zz));
          chk("o_data_rs", 32'(o_data_rs), 32'(e.rs));
          chk("o_first", 32'({o_first_zz, o_first_rs}), 32'({e.first, e.first}));
          chk("o_last", 32'({o_last_zz, o_last_rs}), 32'({e.last, e.last}));
          if (i_ready) begin
            void'(sb.pop_front());
            emitted++;
          end
        end
      end
    end
  end

  initial begin : main
    int r, c, n, start;
    r = 0;
    c = 0;
    for (int k = 0; k < N; k++) begin
      zz_lin[k] = r*M + c;
      if ((r + c) % 2 == 0) begin
        if (c == M-1)   r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == M-1)   c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end

    repeat (3) step();
    rst = 1'b0;
    step();

    add_block(1'b0, 1'b1);
    drain(300);
    add_block(1'b0, 1'b0);
    drain(300);

    repeat (3) add_block(1'b1, 1'($urandom));
    drain(600);

    ready_pct = 50;
    repeat (4) add_block(1'b1, 1'($urandom));
    drain(3000);
    ready_pct = 100;

    repeat (2) add_block(1'b1, 1'b1);
    repeat (100) step();
    add_block(1'b1, 1'b0);
    drain(600);
    repeat (5) step();

    repeat (3) add_block(1'b1, 1'b1);
    start = emitted;
    n = 0;
    while (emitted < start + 30 && n < 500) begin
      step();
      n++;
    end
    chk("k30_timeout", 32'(n >= 500), 32'd0);
    rst = 1'b1;
    i_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    hold_empty = 1'b1;
    i_empty = 1'b1;
    i_valid = 1'b1;
    i_mcu = '1;
    i_last = 1'b1;
    step();
    hold_empty = 1'b0;
    drain(600);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcu_serializer.md
# mcu_serializer

Read-side drain for the MCU FIFO: pops one whole MCU_SIZE×MCU_SIZE block at a time from the FIFO's parallel output and emits its coefficients one per cycle on a valid/ready stream, in zigzag or raster order. Sits between the MCU FIFO and the downstream per-coefficient stage (run-length/Huffman path). It double-buffers blocks so that consecutive blocks stream back-to-back with no bubble.

## Interface
- MCU_SIZE, 8, block edge length; block holds N = MCU_SIZE*MCU_SIZE elements.
- BIT_WIDTH, 12, bits per element.
- ZIGZAG, 1, 1 = JPEG zigzag order, 0 = row-major raster order.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- o_re  out  1  FIFO read strobe (combinational).
- i_empty  in  1  FIFO empty.
- i_mcu  in  [0:MCU_SIZE-1][0:MCU_SIZE-1][BIT_WIDTH-1:0]  FIFO block data; [0][0] is top-left (DC).
- i_last  in  1  FIFO last-block flag, qualified by i_valid.
- i_valid  in  1  FIFO data valid; high exactly one cycle after an accepted read.
- o_data  out  BIT_WIDTH  current element.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts when o_valid & i_ready.
- o_first  out  1  current element is element 0 of a block.
- o_last  out  1  current element is element N-1 of a block whose i_last was 1.

## Operation
- Two block registers: ACTIVE (being emitted) and SHADOW (prefetched), each with a valid bit, plus `pend` (read issued, data not yet returned) and element counter k (0..N-1, width clog2(N)).
- o_re = !rst & !i_empty & !pend & !shadow_valid & !(active_valid & pend). Net effect: at most one read outstanding; a read is issued only when a free register is guaranteed at return.
- pend sets on o_re, clears on i_valid.
- On i_valid: if ACTIVE free (or freed this cycle by the final handshake) load ACTIVE with i_mcu/i_last, k=0; else load SHADOW.
- Buffer states: EMPTY (none valid), ONE (ACTIVE only), TWO (both). EMPTY→ONE on i_valid; ONE→TWO on i_valid while ACTIVE busy; TWO→ONE on final handshake (SHADOW moves to ACTIVE, k=0, same cycle); ONE→EMPTY on final handshake with no i_valid; ONE stays ONE on final handshake coinciding with i_valid (new block goes straight to ACTIVE).
- Handshake: k increments on o_valid & i_ready; final handshake is at k = N-1.
- Order: element k maps to (row,col) via a fixed table; ZIGZAG=1 uses the anti-diagonal traversal (for MCU_SIZE=8, standard JPEG sequence 0,1,8,16,9,2,3,10,... by linear index row*8+col); ZIGZAG=0 uses row = k / MCU_SIZE, col = k % MCU_SIZE.
- o_data = ACTIVE[row(k)][col(k)]; o_first = o_valid & (k==0); o_last = o_valid & (k==N-1) & active_last.
- i_valid while both registers valid is illegal; must be an assertion failure, never reachable by construction.

## Timing
- Reset: o_valid=0, o_first=0, o_last=0, o_data=0, pend=0, both valid bits 0, k=0; o_re=0 while rst high.
- rst mid-block: partial block and any outstanding read discarded; an i_valid arriving the cycle after rst deasserts is ignored (pend already 0).
- Latency: FIFO non-empty with serializer EMPTY at cycle 0 → o_re cycle 0, i_valid cycle 1, o_valid and element 0 at cycle 2.
- o_valid, o_data, o_first, o_last are registered/derived from registered state; o_data stable while o_valid & !i_ready.
- Steady state with i_ready held high and FIFO never empty: N outputs per block, zero idle cycles between blocks.
- i_ready low stalls k indefinitely; prefetch continues until TWO.

## Test plan
- Single block, MCU_SIZE=8, ZIGZAG=1, element value = linear index, i_ready=1 → o_data sequence 0,1,8,16,9,2,... ending 63; o_first on first cycle only; first o_valid two cycles after o_re.
- Same with ZIGZAG=0 → o_data 0..63 in order; o_last=1 only on value 63 when i_last=1, never when i_last=0.
- Three blocks pre-loaded, i_ready=1 → 192 consecutive o_valid cycles, no gap; o_re asserted only when a register is free; no more than one read outstanding.
- Random i_ready (50%) over 4 blocks → output sequence identical to unstalled case; o_data held while stalled.
- FIFO goes empty mid-stream → o_valid drops after element 63 of last block, o_re=0 while i_empty=1, resumes with 2-cycle latency.
- rst asserted at k=30 with SHADOW full → next cycle all outputs 0; subsequent block begins at k=0 with o_first=1.
